// File: rtl/intra_pred_4x4.sv
// H.264-style 4x4 luma intra mode decision: vertical, horizontal and DC predictions, minimum-SAD pick.
// Optional macro INTRAPRED_FORCE_EN adds force_valid/force_mode to restrict evaluation to a single mode.
module intra_pred_4x4 #(
  parameter int MB_WIDTH = 120,
  parameter int MB_COUNT = 8160
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [12:0]  mbnumber,
  input  logic         start,
  input  logic [31:0]  top_pix,
  input  logic [31:0]  left_pix,
  input  logic [127:0] cur_pix,
`ifdef INTRAPRED_FORCE_EN
  input  logic         force_valid,
  input  logic [1:0]   force_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic [1:0]   best_mode,
  output logic [11:0]  best_sad,
  output logic [127:0] pred_pix
);

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_DONE} state_t;

  state_t        r_state;
  logic [31:0]   r_top;
  logic [31:0]   r_left;
  logic [127:0]  r_cur;
  logic          r_top_av;
  logic          r_left_av;
  logic          r_best_valid;
  logic [1:0]    r_best_mode;
  logic [11:0]   r_best_sad;
  logic [127:0]  r_best_pred;
`ifdef INTRAPRED_FORCE_EN
  logic          r_force_valid;
  logic [1:0]    r_force_mode;
  logic          w_force_av;
  logic [1:0]    w_force_eff;
`endif

  logic [1:0]    w_mode;
  logic          w_mode_av;
  logic          w_cand_valid;
  logic          w_take;
  logic          w_in_range;
  logic [11:0]   w_sum_top;
  logic [11:0]   w_sum_left;
  logic [7:0]    w_dc;
  logic [127:0]  w_pred;
  logic [11:0]   w_sad;

  function automatic logic [11:0] sad16(input logic [127:0] a, input logic [127:0] b);
    logic [11:0] acc;
    logic [7:0]  x;
    logic [7:0]  y;
    acc = 12'd0;
    for (int i = 0; i < 16; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      acc = acc + 12'((x > y) ? (x - y) : (y - x));
    end
    return acc;
  endfunction

  assign w_in_range = (mbnumber < 13'(MB_COUNT));

  // Neighbour sums and the DC value for the latched block.
  always_comb begin
    w_sum_top  = 12'd0;
    w_sum_left = 12'd0;
    for (int i = 0; i < 4; i++) begin
      w_sum_top  = w_sum_top  + 12'(r_top[8*i +: 8]);
      w_sum_left = w_sum_left + 12'(r_left[8*i +: 8]);
    end
    if (r_top_av && r_left_av) begin
      w_dc = 8'((w_sum_top + w_sum_left + 12'd4) >> 3);
    end else if (r_top_av) begin
      w_dc = 8'((w_sum_top + 12'd2) >> 2);
    end else if (r_left_av) begin
      w_dc = 8'((w_sum_left + 12'd2) >> 2);
    end else begin
      w_dc = 8'd128;
    end
  end

  // Mode under evaluation in the current state, its prediction and SAD.
  always_comb begin
    case (r_state)
      S_M0:    w_mode = 2'd0;
      S_M1:    w_mode = 2'd1;
      default: w_mode = 2'd2;
    endcase
    w_pred = 128'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (w_mode)
          2'd0:    w_pred[8*(4*r+c) +: 8] = r_top[8*c +: 8];
          2'd1:    w_pred[8*(4*r+c) +: 8] = r_left[8*r +: 8];
          default: w_pred[8*(4*r+c) +: 8] = w_dc;
        endcase
      end
    end
    w_sad = sad16(r_cur, w_pred);
  end

  // Candidate validity, including the forced-mode restriction when built in.
  always_comb begin
    case (w_mode)
      2'd0:    w_mode_av = r_top_av;
      2'd1:    w_mode_av = r_left_av;
      default: w_mode_av = 1'b1;
    endcase
`ifdef INTRAPRED_FORCE_EN
    case (r_force_mode)
      2'd0:    w_force_av = r_top_av;
      2'd1:    w_force_av = r_left_av;
      2'd2:    w_force_av = 1'b1;
      default: w_force_av = 1'b0;
    endcase
    if (w_force_av) begin
      w_force_eff = r_force_mode;
    end else begin
      w_force_eff = 2'd2;
    end
    if (r_force_valid) begin
      w_cand_valid = (w_mode == w_force_eff);
    end else begin
      w_cand_valid = w_mode_av;
    end
`else
    w_cand_valid = w_mode_av;
`endif
    // Strict less-than keeps the earlier (lower-numbered) mode on ties.
    w_take = w_cand_valid && ((r_state == S_M0) || !r_best_valid || (w_sad < r_best_sad));
  end

  // Sequencer, best-mode tracking and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_top         <= 32'd0;
      r_left        <= 32'd0;
      r_cur         <= 128'd0;
      r_top_av      <= 1'b0;
      r_left_av     <= 1'b0;
      r_best_valid  <= 1'b0;
      r_best_mode   <= 2'd0;
      r_best_sad    <= 12'd0;
      r_best_pred   <= 128'd0;
`ifdef INTRAPRED_FORCE_EN
      r_force_valid <= 1'b0;
      r_force_mode  <= 2'd0;
`endif
      busy          <= 1'b0;
      done          <= 1'b0;
      best_mode     <= 2'd0;
      best_sad      <= 12'd0;
      pred_pix      <= 128'd0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && w_in_range) begin
            r_top     <= top_pix;
            r_left    <= left_pix;
            r_cur     <= cur_pix;
            r_top_av  <= (mbnumber >= 13'(MB_WIDTH));
            r_left_av <= ((mbnumber % 13'(MB_WIDTH)) != 13'd0);
`ifdef INTRAPRED_FORCE_EN
            r_force_valid <= force_valid;
            r_force_mode  <= force_mode;
`endif
            busy      <= 1'b1;
            r_state   <= S_M0;
          end
        end
        S_M0, S_M1, S_M2: begin
          if (r_state == S_M0) begin
            r_best_valid <= w_cand_valid;
          end
          if (w_take) begin
            r_best_valid <= 1'b1;
            r_best_mode  <= w_mode;
            r_best_sad   <= w_sad;
            r_best_pred  <= w_pred;
          end
          case (r_state)
            S_M0:    r_state <= S_M1;
            S_M1:    r_state <= S_M2;
            default: r_state <= S_DONE;
          endcase
        end
        S_DONE: begin
          best_mode <= r_best_mode;
          best_sad  <= r_best_sad;
          pred_pix  <= r_best_pred;
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_pred_4x4.sv
// Directed scoreboard bench for intra_pred_4x4.
module tb_intra_pred_4x4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [12:0]  mbnumber;
  logic         start;
  logic [31:0]  top_pix;
  logic [31:0]  left_pix;
  logic [127:0] cur_pix;
  logic         busy;
  logic         done;
  logic [1:0]   best_mode;
  logic [11:0]  best_sad;
  logic [127:0] pred_pix;

  typedef struct {
    logic [1:0]   mode;
    logic [11:0]  sad;
    logic [127:0] pred;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  intra_pred_4x4 dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mbnumber (mbnumber),
    .start    (start),
    .top_pix  (top_pix),
    .left_pix (left_pix),
    .cur_pix  (cur_pix),
`ifdef INTRAPRED_FORCE_EN
    .force_valid (1'b0),
    .force_mode  (2'd0),
`endif
    .busy     (busy),
    .done     (done),
    .best_mode(best_mode),
    .best_sad (best_sad),
    .pred_pix (pred_pix)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: availability, DC rule, SAD, strict-less selection in mode order.
  function automatic exp_t model(input logic [12:0] mb, input logic [31:0] t,
                                 input logic [31:0] l, input logic [127:0] cur);
    exp_t         e;
    bit           tav;
    bit           lav;
    bit           have;
    int           st;
    int           sl;
    int           dc;
    int           p;
    int           x;
    int           sad;
    logic [127:0] pr;
    tav = (mb >= 13'd120);
    lav = ((mb % 120) != 0);
    st = 0;
    sl = 0;
    for (int i = 0; i < 4; i++) begin
      st += int'(t[8*i +: 8]);
      sl += int'(l[8*i +: 8]);
    end
    if (tav && lav) dc = (st + sl + 4) / 8;
    else if (tav)   dc = (st + 2) / 4;
    else if (lav)   dc = (sl + 2) / 4;
    else            dc = 128;
    have = 1'b0;
    e.mode = 2'd0;
    e.sad = 12'd0;
    e.pred = 128'd0;
    for (int m = 0; m < 3; m++) begin
      if ((m == 0 && !tav) || (m == 1 && !lav)) continue;
      sad = 0;
      pr = 128'd0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (m == 0)      p = int'(t[8*c +: 8]);
          else if (m == 1) p = int'(l[8*r +: 8]);
          else             p = dc;
          x = int'(cur[8*(4*r+c) +: 8]);
          sad += (x > p) ? (x - p) : (p - x);
          pr[8*(4*r+c) +: 8] = 8'(p);
        end
      end
      if (!have || sad < int'(e.sad)) begin
        have = 1'b1;
        e.mode = 2'(m);
        e.sad = 12'(sad);
        e.pred = pr;
      end
    end
    return e;
  endfunction

  task automatic wait_done(input string tag, input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    chk($sformatf("%s_done_seen", tag), done, 1'b1);
  endtask

  task automatic sb_check(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      chk($sformatf("%s_sb_empty", tag), 1'b1, 1'b0);
      e.mode = 2'd0;
      e.sad = 12'd0;
      e.pred = 128'd0;
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s_mode", tag), best_mode, e.mode);
      chk($sformatf("%s_sad", tag), best_sad, e.sad);
      chk($sformatf("%s_pred", tag), pred_pix, e.pred);
    end
  endtask

  task automatic drive_start(input logic [12:0] mb, input logic [31:0] t,
                             input logic [31:0] l, input logic [127:0] cur);
    mbnumber = mb;
    top_pix  = t;
    left_pix = l;
    cur_pix  = cur;
    start    = 1'b1;
    sb.push_back(model(mb, t, l, cur));
    step();
    start    = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic [12:0] mb, input logic [31:0] t,
                         input logic [31:0] l, input logic [127:0] cur);
    int   cyc;
    exp_t e;
    drive_start(mb, t, l, cur);
    chk($sformatf("%s_busy", tag), busy, 1'b1);
    wait_done(tag, 0, cyc);
    chk($sformatf("%s_latency", tag), 128'(cyc), 128'd4);
    sb_check(tag, e);
    step();
    chk($sformatf("%s_pulse", tag), done, 1'b0);
    chk($sformatf("%s_hold", tag), best_sad, e.sad);
  endtask

  initial begin
    int   cyc;
    bit   seen_busy;
    bit   seen_done;
    exp_t e;

    reset = 1'b0; enable = 1'b1; start = 1'b0; mbnumber = 13'd0;
    top_pix = 32'd0; left_pix = 32'd0; cur_pix = 128'd0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mode", best_mode, 2'd0);
    chk("rst_sad", best_sad, 12'd0);
    chk("rst_pred", pred_pix, 128'd0);
    reset = 1'b1;
    step();

    run_txn("both", 13'd121, {4{8'd50}}, {4{8'd200}}, {16{8'd200}});
    chk("both_mode_const", best_mode, 2'd1);
    chk("both_pred_const", pred_pix, {16{8'd200}});

    run_txn("vert", 13'd120, {8'd40, 8'd30, 8'd20, 8'd10}, {4{8'd77}},
            {4{8'd40, 8'd30, 8'd20, 8'd10}});
    chk("vert_mode_const", best_mode, 2'd0);
    chk("vert_sad_const", best_sad, 12'd0);

    run_txn("none", 13'd0, {4{8'd9}}, {4{8'd9}}, {16{8'd130}});
    chk("none_mode_const", best_mode, 2'd2);
    chk("none_sad_const", best_sad, 12'd32);
    chk("none_pred_const", pred_pix, {16{8'd128}});

    // Tie, start while busy, and enable gap.
    drive_start(13'd121, {4{8'd100}}, {4{8'd100}}, {16{8'd100}});
    mbnumber = 13'd5; top_pix = 32'd0; left_pix = 32'hFFFF_FFFF; cur_pix = {16{8'd3}};
    start = 1'b1;
    step();
    chk("tie_busy", busy, 1'b1);
    start = 1'b0; enable = 1'b0;
    step(); step(); step();
    chk("tie_frozen", done, 1'b0);
    enable = 1'b1;
    wait_done("tie", 4, cyc);
    chk("tie_latency", 128'(cyc), 128'd7);
    sb_check("tie", e);
    chk("tie_mode_const", best_mode, 2'd0);
    step();
    chk("tie_pulse", done, 1'b0);
    chk("tie_no_restart", busy, 1'b0);

    // Done pulse stretches while enable is low.
    drive_start(13'd8159, {4{8'd60}}, {8'd1, 8'd90, 8'd45, 8'd200}, {16{8'd70}});
    wait_done("stretch", 0, cyc);
    sb_check("stretch", e);
    enable = 1'b0;
    step(); step();
    chk("stretch_held", done, 1'b1);
    chk("stretch_sad_held", best_sad, e.sad);
    enable = 1'b1;
    step();
    chk("stretch_drop", done, 1'b0);

    // Out-of-range macroblock number.
    mbnumber = 13'd8160; start = 1'b1;
    step();
    start = 1'b0;
    seen_busy = 1'b0; seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) seen_busy = 1'b1;
      if (done) seen_done = 1'b1;
      step();
    end
    chk("range_busy", seen_busy, 1'b0);
    chk("range_done", seen_done, 1'b0);

    run_txn("edge119", 13'd119, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
    run_txn("mb240", 13'd240, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
    run_txn("mb4321", 13'd4321, {4{8'd128}}, $urandom, {$urandom, $urandom, $urandom, $urandom});
    run_txn("mb2", 13'd2, {4{8'd0}}, {4{8'd255}}, {16{8'd0}});

    // Reset mid-operation.
    run_txn("pre_rst", 13'd0, 32'd0, 32'd0, {16{8'd255}});
    drive_start(13'd121, {4{8'd1}}, {4{8'd2}}, {16{8'd3}});
    void'(sb.pop_back());
    step();
    chk("midrst_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_mode", best_mode, 2'd0);
    chk("midrst_sad", best_sad, 12'd0);
    chk("midrst_pred", pred_pix, 128'd0);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) seen_done = 1'b1;
    end
    chk("midrst_no_done", seen_done, 1'b0);

    run_txn("recover", 13'd600, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});

    if (n_pass + n_fail != n_total) $error("FAIL bookkeeping: observed %0d expected %0d", n_pass + n_fail, n_total);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/intra_pred_4x4.md
Name: intra_pred_4x4

Overview:
- H.264-style 4x4 luma intra-prediction mode decision engine.
- Derives neighbour availability from the macroblock number, then builds the vertical, horizontal and DC predictions.
- Picks the available mode with the minimum SAD against the current block.
- Returns the winning mode, its SAD and its predicted block to the encoder datapath.

Parameters:
- MB_WIDTH, 120, frame width in macroblocks.
- MB_COUNT, 8160, total macroblocks per frame (MB_WIDTH x 68).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- enable  in  1  clock enable; when 0 the FSM and all registers hold.
- mbnumber  in  13  macroblock index of the block being predicted, raster order.
- start  in  1  request pulse; sampled only in IDLE with enable=1.
- top_pix  in  32  row above; column c at [8c+7:8c].
- left_pix  in  32  column left; row r at [8r+7:8r].
- cur_pix  in  128  current block; pixel (r,c) at [8(4r+c)+7 : 8(4r+c)].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- best_mode  out  2  0=vertical, 1=horizontal, 2=DC.
- best_sad  out  12  SAD of best_mode, 0..4080.
- pred_pix  out  128  prediction of best_mode, same packing as cur_pix.

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, best_mode, best_sad and pred_pix are all 0.
- Accept: in IDLE with enable=1, start=1 and mbnumber < MB_COUNT:
  - latch top_pix, left_pix and cur_pix;
  - compute top_av = (mbnumber >= MB_WIDTH);
  - compute left_av = (mbnumber mod MB_WIDTH != 0);
  - go to M0.
- Out-of-range start (mbnumber >= MB_COUNT): ignored; state stays IDLE and done is not pulsed.
- States: IDLE -> M0 (vertical) -> M1 (horizontal) -> M2 (DC) -> DONE -> IDLE. Each state takes exactly one enabled cycle.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+4.
- enable=0 freezes the state and all outputs. A done pulse stretches while enable=0.
- Predictions:
  - Vertical: pred(r,c)=top(c). Valid only if top_av.
  - Horizontal: pred(r,c)=left(r). Valid only if left_av.
  - DC, both neighbours available: (sum top + sum left + 4)>>3.
  - DC, top only: (sum top + 2)>>2.
  - DC, left only: (sum left + 2)>>2.
  - DC, neither available: 128. DC is always valid.
- SAD is the sum over 16 pixels of |cur - pred|, 8-bit unsigned operands, unsigned 12-bit result, no saturation needed.
- Selection: an internal best register is initialised invalid in M0.
  - A valid mode replaces the best if the best is invalid or the new SAD is strictly less.
  - Ties keep the lower mode number.
  - An unavailable mode still consumes its cycle and is never selected.
- DONE: register best_mode, best_sad and pred_pix, pulse done, drop busy.
  - Outputs then hold until the next DONE or reset.
- start during busy is ignored; inputs are not re-latched.
- reset asserted mid-operation: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: INTRAPRED_FORCE_EN.
- When defined, adds inputs force_valid (1 bit) and force_mode (2 bits), both latched with start.
  - If force_valid=1, only force_mode is evaluated.
  - If force_mode is unavailable or equal to 3, DC is used.
  - Latency is unchanged.
- Without the macro, these ports do not exist and all three modes are always evaluated.

Test Plan:
- Reset check: assert reset=0 mid-run with busy=1 -> outputs 0 and busy=0 immediately; no done follows.
- Both neighbours available: mbnumber=121, top=all 50, left=all 200, cur rows=all 200 -> best_mode=1, best_sad=0, pred rows=200, done 4 cycles after start.
- Vertical wins: mbnumber=120 (left unavailable), top={10,20,30,40}, cur=each row {10,20,30,40} -> best_mode=0, best_sad=0.
- No neighbours: mbnumber=0, cur=all 130 -> best_mode=2, pred=all 128, best_sad=32.
- Tie rule and protocol: mbnumber=121, top=all 100, left=all 100, cur=all 100 -> best_mode=0 with SAD 0; a second start while busy is ignored; enable=0 for 3 cycles delays done by 3 cycles.
- Range check: mbnumber=8160 with start=1 -> busy stays 0 and no done pulse.
